// File: rtl/fir_ctrl_flex.sv
//------------------------------------------------------------------------------
// Module      : fir_ctrl_flex
// Description : Control sequencer for a multiplexed-MAC FIR filter. Per input
//               sample it issues a delay-chain shift, then TAPS accumulate
//               cycles with a tap index, then an output-valid pulse. It can also
//               run a coefficient-reload sweep of TAPS write strobes.
//               Optional feature macro: FIR_CTRL_OVERRUN_EN adds a sticky flag
//               that is set when a sample is offered while the block is busy.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_ctrl_flex #(
  parameter int TAPS  = 10,
  parameter int SEL_W = 4
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iFirEn,
  input  logic             iInValid,
  input  logic             iUpdReq,
  input  logic             iClrErr,
  output logic             oInReady,
  output logic             oEnDelay,
  output logic             oMacClr,
  output logic             oMacEn,
  output logic [SEL_W-1:0] oTapSel,
  output logic             oCoefWrEn,
  output logic [SEL_W-1:0] oCoefAddr,
  output logic             oOutValid,
  output logic             oOverrun
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SHIFT = 3'd1;
  localparam logic [2:0] c_ST_MAC   = 3'd2;
  localparam logic [2:0] c_ST_DONE  = 3'd3;
  localparam logic [2:0] c_ST_UPD   = 3'd4;

  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(TAPS - 1);

  logic [2:0]       state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;

  logic             en_delay_q, en_delay_d;
  logic             mac_clr_q, mac_clr_d;
  logic             mac_en_q, mac_en_d;
  logic [SEL_W-1:0] tap_sel_q, tap_sel_d;
  logic             coef_wr_q, coef_wr_d;
  logic [SEL_W-1:0] coef_addr_q, coef_addr_d;
  logic             out_valid_q, out_valid_d;

  // State and step counter register; reset returns to IDLE immediately.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= c_ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; disabling the block aborts any sequence back to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!iFirEn) begin
      state_d = c_ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          cnt_d = '0;
          // A new sample takes priority over a pending reload request.
          if (iInValid) begin
            state_d = c_ST_SHIFT;
          end else if (iUpdReq) begin
            state_d = c_ST_UPD;
          end
        end
        c_ST_SHIFT: begin
          state_d = c_ST_MAC;
          cnt_d   = '0;
        end
        c_ST_MAC: begin
          if (cnt_q == c_LAST) begin
            state_d = c_ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        c_ST_DONE: begin
          state_d = c_ST_IDLE;
          cnt_d   = '0;
        end
        c_ST_UPD: begin
          if (cnt_q == c_LAST) begin
            state_d = c_ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = c_ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the strobes line up with it once registered.
  always_comb begin
    en_delay_d  = 1'b0;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    tap_sel_d   = '0;
    coef_wr_d   = 1'b0;
    coef_addr_d = '0;
    out_valid_d = 1'b0;
    case (state_d)
      c_ST_SHIFT: begin
        en_delay_d = 1'b1;
        mac_clr_d  = 1'b1;
      end
      c_ST_MAC: begin
        mac_en_d  = 1'b1;
        tap_sel_d = cnt_d;
      end
      c_ST_DONE: begin
        out_valid_d = 1'b1;
      end
      c_ST_UPD: begin
        coef_wr_d   = 1'b1;
        coef_addr_d = cnt_d;
      end
      default: begin
        en_delay_d = 1'b0;
      end
    endcase
  end

  // Registered strobes and indices.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      en_delay_q  <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      tap_sel_q   <= '0;
      coef_wr_q   <= 1'b0;
      coef_addr_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      en_delay_q  <= en_delay_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      tap_sel_q   <= tap_sel_d;
      coef_wr_q   <= coef_wr_d;
      coef_addr_q <= coef_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign oInReady  = (state_q == c_ST_IDLE);
  assign oEnDelay  = en_delay_q;
  assign oMacClr   = mac_clr_q;
  assign oMacEn    = mac_en_q;
  assign oTapSel   = tap_sel_q;
  assign oCoefWrEn = coef_wr_q;
  assign oCoefAddr = coef_addr_q;
  assign oOutValid = out_valid_q;

`ifdef FIR_CTRL_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun: a sample offered while not ready sets it, and set beats clear.
  always_comb begin
    ovr_d = ovr_q;
    if (iInValid && !oInReady) begin
      ovr_d = 1'b1;
    end else if (iClrErr) begin
      ovr_d = 1'b0;
    end
  end

  // Overrun flag register.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign oOverrun = ovr_q;
`else
  logic w_unused_clr;
  assign w_unused_clr = iClrErr;
  assign oOverrun     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_ctrl_flex.sv
//------------------------------------------------------------------------------
// Module      : tb_fir_ctrl_flex
// Description : Self-checking bench for fir_ctrl_flex. A behavioural model
//               tracks which job is running (none / sample / reload) and how
//               many cycles into it, and the expected outputs are derived from
//               that position every cycle. Directed sequences add literal
//               expectations, then randomized stimulus runs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_ctrl_flex;

  localparam int TAPS  = 10;
  localparam int SEL_W = 4;
  localparam int VW    = 7 + 2 * SEL_W;

  logic             iClk = 1'b0;
  logic             iRsn = 1'b0;
  logic             iFirEn = 1'b0;
  logic             iInValid = 1'b0;
  logic             iUpdReq = 1'b0;
  logic             iClrErr = 1'b0;
  logic             oInReady, oEnDelay, oMacClr, oMacEn, oCoefWrEn, oOutValid, oOverrun;
  logic [SEL_W-1:0] oTapSel, oCoefAddr;

  fir_ctrl_flex #(.TAPS(TAPS), .SEL_W(SEL_W)) dut (
    .iClk      (iClk),
    .iRsn      (iRsn),
    .iFirEn    (iFirEn),
    .iInValid  (iInValid),
    .iUpdReq   (iUpdReq),
    .iClrErr   (iClrErr),
    .oInReady  (oInReady),
    .oEnDelay  (oEnDelay),
    .oMacClr   (oMacClr),
    .oMacEn    (oMacEn),
    .oTapSel   (oTapSel),
    .oCoefWrEn (oCoefWrEn),
    .oCoefAddr (oCoefAddr),
    .oOutValid (oOutValid),
    .oOverrun  (oOverrun)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Model: job kind (0 none, 1 sample, 2 reload) and cycles elapsed in it.
  int m_kind = 0;
  int m_p    = 0;
  bit m_ovr  = 1'b0;

  always @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      m_kind <= 0;
      m_p    <= 0;
      m_ovr  <= 1'b0;
    end else begin
`ifdef FIR_CTRL_OVERRUN_EN
      if (iInValid && m_kind != 0) m_ovr <= 1'b1;
      else if (iClrErr)            m_ovr <= 1'b0;
`endif
      if (!iFirEn) begin
        m_kind <= 0;
        m_p    <= 0;
      end else if (m_kind == 0) begin
        m_p    <= 0;
        m_kind <= iInValid ? 1 : (iUpdReq ? 2 : 0);
      end else if ((m_kind == 1 && m_p == TAPS + 1) || (m_kind == 2 && m_p == TAPS - 1)) begin
        m_kind <= 0;
        m_p    <= 0;
      end else begin
        m_p <= m_p + 1;
      end
    end
  end

  function automatic logic [VW-1:0] model_vec();
    logic rdy, ed, me, wr, ov;
    logic [SEL_W-1:0] ts, ca;
    rdy = (m_kind == 0);
    ed  = (m_kind == 1) && (m_p == 0);
    me  = (m_kind == 1) && (m_p >= 1) && (m_p <= TAPS);
    ts  = me ? SEL_W'(m_p - 1) : '0;
    ov  = (m_kind == 1) && (m_p == TAPS + 1);
    wr  = (m_kind == 2);
    ca  = wr ? SEL_W'(m_p) : '0;
    return {rdy, ed, ed, me, ts, wr, ca, ov, m_ovr};
  endfunction

  logic [VW-1:0] act;
  assign act = {oInReady, oEnDelay, oMacClr, oMacEn, oTapSel, oCoefWrEn, oCoefAddr, oOutValid, oOverrun};

  // Per-cycle comparison against the model, sampled after the edge settles.
  always @(posedge iClk) begin
    #1;
    checks++;
    if (act !== model_vec()) begin
      errors++;
      $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time, act, model_vec());
    end
  end

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, a, e);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_ready", int'(oInReady), 1);
    chk("reset_macen", int'(oMacEn), 0);
    chk("reset_ovr", int'(oOverrun), 0);
    iRsn   = 1'b1;
    iFirEn = 1'b1;
    tick();

    // Single sample sequence
    iInValid = 1'b1;
    tick();
    chk("shift_endelay", int'(oEnDelay), 1);
    chk("shift_macclr", int'(oMacClr), 1);
    chk("shift_ready", int'(oInReady), 0);
    iInValid = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      tick();
      chk("mac_en", int'(oMacEn), 1);
      chk("mac_tapsel", int'(oTapSel), k);
    end
    tick();
    chk("done_outvalid", int'(oOutValid), 1);
    tick();
    chk("idle_ready", int'(oInReady), 1);
    chk("idle_outvalid", int'(oOutValid), 0);

    // Reload sweep, with samples offered during it
    iUpdReq = 1'b1;
    tick();
    chk("upd_wr", int'(oCoefWrEn), 1);
    chk("upd_addr0", int'(oCoefAddr), 0);
    iInValid = 1'b1;
    for (int k = 1; k < TAPS; k++) begin
      tick();
      chk("upd_addr", int'(oCoefAddr), k);
      chk("upd_ready", int'(oInReady), 0);
    end
    tick();
    chk("upd_end_ready", int'(oInReady), 1);
    chk("upd_end_wr", int'(oCoefWrEn), 0);
    chk("upd_no_accept", int'(oEnDelay), 0);
    iInValid = 1'b0;
    iUpdReq  = 1'b0;
`ifdef FIR_CTRL_OVERRUN_EN
    chk("ovr_set", int'(oOverrun), 1);
    iClrErr = 1'b1;
    tick();
    iClrErr = 1'b0;
    chk("ovr_clr", int'(oOverrun), 0);
`else
    chk("ovr_tied", int'(oOverrun), 0);
`endif

    // Sample and reload requested together: sample first
    iInValid = 1'b1;
    iUpdReq  = 1'b1;
    tick();
    chk("both_shift", int'(oEnDelay), 1);
    iInValid = 1'b0;
    repeat (11) tick();
    chk("both_done", int'(oOutValid), 1);
    tick();
    chk("both_idle", int'(oInReady), 1);
    tick();
    chk("both_upd_wr", int'(oCoefWrEn), 1);
    chk("both_upd_addr", int'(oCoefAddr), 0);
    iUpdReq = 1'b0;
    repeat (10) tick();
    chk("both_back_idle", int'(oInReady), 1);

    // Abort by disabling at tap 5
    iInValid = 1'b1;
    tick();
    iInValid = 1'b0;
    repeat (6) tick();
    chk("abort_tap5", int'(oTapSel), 5);
    iFirEn = 1'b0;
    tick();
    chk("abort_macen", int'(oMacEn), 0);
    chk("abort_ready", int'(oInReady), 1);
    iFirEn = 1'b1;
    repeat (14) tick();

    // Asynchronous reset mid-MAC
    iInValid = 1'b1;
    tick();
    iInValid = 1'b0;
    repeat (4) tick();
    #2;
    iRsn = 1'b0;
    #1;
    chk("arst_macen", int'(oMacEn), 0);
    chk("arst_tapsel", int'(oTapSel), 0);
    chk("arst_ready", int'(oInReady), 1);
    tick();
    iRsn = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      iInValid = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 10) iUpdReq = ~iUpdReq;
      iFirEn  = ($urandom_range(0, 99) >= 3);
      iClrErr = ($urandom_range(0, 99) < 10);
      tick();
    end
    iInValid = 1'b0;
    iUpdReq  = 1'b0;
    iClrErr  = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
